// File: rtl/pll_supervisor_pkg.sv
// Shared types for the PLL lock supervisor: sequencing states and the
// helper that sizes the single shared cycle counter.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } state_e;

  function automatic int clog2_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals asynchronous to clk; 2-cycle latency,
// synchronous active-high reset clears both stages to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock acquisition (timeout + bounded retries, stability window)
// and staggered release of N_OUT domain resets; all outputs registered off next state.
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int N_OUT               = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_STAGGER_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pll_lock,
  output logic                              pll_rst,
  output logic [N_OUT-1:0]                  out_rst,
  output logic                              ready,
  output logic                              fail,
  output logic [$clog2(MAX_RETRIES+2)-1:0]  retry_count,
  output logic [7:0]                        lost_lock_cnt
);

  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int CW = clog2_max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                LOCK_STABLE_CYCLES, RST_STAGGER_CYCLES) + 1;

  localparam logic [CW-1:0] C_RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_STAGGER_LAST = CW'(RST_STAGGER_CYCLES - 1);
  localparam logic [RW-1:0] C_MAX_RETRY    = RW'(MAX_RETRIES);

  logic             w_lock_s;
  state_e           r_state,   w_state_nxt;
  logic [CW-1:0]    r_cnt,     w_cnt_nxt;
  logic [N_OUT-1:0] r_out_rst, w_out_rst_nxt;
  logic [RW-1:0]    r_retry,   w_retry_nxt;
  logic [7:0]       r_lost,    w_lost_nxt;
  logic             r_pll_rst;
  logic             r_ready;
  logic             r_fail;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock),
    .o_q (w_lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PLL_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_out_rst_nxt = r_out_rst;
    w_retry_nxt   = r_retry;
    w_lost_nxt    = r_lost;

    unique case (r_state)
      PLL_RST: begin
        if (r_cnt == C_RST_LAST) w_state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABLE;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          if (r_retry == C_MAX_RETRY) begin
            w_state_nxt = FAIL;
          end else begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = PLL_RST;
          end
        end
      end
      STABLE: begin
        // A lock glitch restarts the wait without costing a retry.
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt   = RELEASE;
          w_out_rst_nxt = r_out_rst << 1;
        end
      end
      RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt   = PLL_RST;
          w_out_rst_nxt = '1;
          if (r_lost != 8'hFF) w_lost_nxt = r_lost + 1'b1;
        end else if (r_out_rst == '0) begin
          w_state_nxt = RUN;
        end else if (r_cnt == C_STAGGER_LAST) begin
          // Shifting in zeros releases domains in index order, never re-asserting one.
          w_out_rst_nxt = r_out_rst << 1;
          w_cnt_nxt     = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt;
        if (!w_lock_s) begin
          w_state_nxt   = PLL_RST;
          w_out_rst_nxt = '1;
          if (r_lost != 8'hFF) w_lost_nxt = r_lost + 1'b1;
        end
      end
      FAIL: begin
        w_cnt_nxt     = r_cnt;
        w_out_rst_nxt = '1;
      end
      default: begin
        w_state_nxt   = PLL_RST;
        w_out_rst_nxt = '1;
      end
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    if (w_state_nxt == RUN)     w_retry_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_rst <= '1;
      r_retry   <= '0;
      r_lost    <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_out_rst <= w_out_rst_nxt;
      r_retry   <= w_retry_nxt;
      r_lost    <= w_lost_nxt;
      r_pll_rst <= (w_state_nxt == PLL_RST) || (w_state_nxt == FAIL);
      r_ready   <= (w_state_nxt == RUN);
      r_fail    <= (w_state_nxt == FAIL);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign out_rst       = r_out_rst;
  assign ready         = r_ready;
  assign fail          = r_fail;
  assign retry_count   = r_retry;
  assign lost_lock_cnt = r_lost;

endmodule
